// File: rtl/mask_a_pkg.sv
`default_nettype none
// ============================================================================
// mask_a_pkg : op encodings and FSM state type shared by the masked-add unit
// Revision   : 1.0
// ============================================================================
package mask_a_pkg;

  typedef enum logic [1:0] {
    OP_ENCODE = 2'b00,
    OP_ADD    = 2'b01,
    OP_REMASK = 2'b10,
    OP_RSVD   = 2'b11
  } mask_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RNG  = 2'b01,
    ST_RSP  = 2'b10
  } mask_state_e;

endpackage : mask_a_pkg
`default_nettype wire

// File: rtl/mask_a_share_alu.sv
`default_nettype none
// ============================================================================
// mask_a_share_alu : combinational arithmetic-share operations (mod 2^XLEN)
// Revision         : 1.0
// ============================================================================
module mask_a_share_alu #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs1_hi,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_rs2_hi,
  input  logic [XLEN-1:0] i_r,
  output logic [XLEN-1:0] o_rd,
  output logic [XLEN-1:0] o_rd_hi
);
  import mask_a_pkg::*;

  // Each output combines only one share kind with r, so no unmasked value appears.
  always_comb begin
    o_rd    = '0;
    o_rd_hi = '0;
    case (mask_op_e'(i_op))
      OP_ENCODE: begin
        o_rd_hi = i_r;
        o_rd    = i_rs1 - i_r;
      end
      OP_ADD: begin
        o_rd_hi = i_rs1_hi + i_rs2_hi + i_r;
        o_rd    = i_rs1 + i_rs2 - i_r;
      end
      OP_REMASK: begin
        o_rd_hi = i_rs1_hi + i_r;
        o_rd    = i_rs1 - i_r;
      end
      default: begin
        o_rd    = '0;
        o_rd_hi = '0;
      end
    endcase
  end

endmodule : mask_a_share_alu
`default_nettype wire

// File: rtl/mask_a_unit.sv
`default_nettype none
// ============================================================================
// mask_a_unit : arithmetic-masked ENCODE/ADD/REMASK with one fresh random word
// Revision    : 1.0
// ============================================================================
module mask_a_unit #(
  parameter int XLEN = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs1_hi,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_rs2_hi,
  output logic            rng_req_valid,
  input  logic            rng_req_ready,
  input  logic [XLEN-1:0] rng_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rd,
  output logic [XLEN-1:0] rsp_rd_hi,
  output logic            rsp_trap
);
  import mask_a_pkg::*;

  mask_state_e     r_state;
  mask_state_e     w_state_nxt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_rs1, r_rs1_hi, r_rs2, r_rs2_hi;
  logic [XLEN-1:0] r_rd, r_rd_hi;
  logic            r_trap;
  logic [XLEN-1:0] w_alu_rd, w_alu_rd_hi;
  logic            w_accept, w_rng_hs, w_rsp_hs, w_req_rsvd;

  assign w_accept   = req_valid & req_ready;
  assign w_rng_hs   = rng_req_valid & rng_req_ready;
  assign w_rsp_hs   = rsp_valid & rsp_ready;
  assign w_req_rsvd = (mask_op_e'(req_op) == OP_RSVD);

  always_ff @(posedge g_clk) begin
    if (g_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    rng_req_valid = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_rsvd ? ST_RSP : ST_RNG;
      end
      ST_RNG: begin
        rng_req_valid = 1'b1;
        if (rng_req_ready) w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  mask_a_share_alu #(.XLEN(XLEN)) u_alu (
    .i_op     (r_op),
    .i_rs1    (r_rs1),
    .i_rs1_hi (r_rs1_hi),
    .i_rs2    (r_rs2),
    .i_rs2_hi (r_rs2_hi),
    .i_r      (rng_data),
    .o_rd     (w_alu_rd),
    .o_rd_hi  (w_alu_rd_hi)
  );

  // Operands live only between acceptance and the RNG handshake; results only while in RSP.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_op     <= '0;
      r_rs1    <= '0;
      r_rs1_hi <= '0;
      r_rs2    <= '0;
      r_rs2_hi <= '0;
      r_rd     <= '0;
      r_rd_hi  <= '0;
      r_trap   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= req_op;
        if (w_req_rsvd) begin
          r_rs1    <= '0;
          r_rs1_hi <= '0;
          r_rs2    <= '0;
          r_rs2_hi <= '0;
          r_rd     <= '0;
          r_rd_hi  <= '0;
          r_trap   <= 1'b1;
        end else begin
          r_rs1    <= req_rs1;
          r_rs1_hi <= req_rs1_hi;
          r_rs2    <= req_rs2;
          r_rs2_hi <= req_rs2_hi;
        end
      end
      if (w_rng_hs) begin
        r_rd     <= w_alu_rd;
        r_rd_hi  <= w_alu_rd_hi;
        r_trap   <= 1'b0;
        r_rs1    <= '0;
        r_rs1_hi <= '0;
        r_rs2    <= '0;
        r_rs2_hi <= '0;
      end
      if (w_rsp_hs) begin
        r_rd    <= '0;
        r_rd_hi <= '0;
        r_trap  <= 1'b0;
      end
    end
  end

  assign rsp_rd    = r_rd;
  assign rsp_rd_hi = r_rd_hi;
  assign rsp_trap  = r_trap;

endmodule : mask_a_unit
`default_nettype wire

// File: tb/tb_mask_a_unit.sv
`default_nettype none
// ============================================================================
// tb_mask_a_unit : directed vector table, corner sequences and random traffic
// Revision       : 1.0
// ============================================================================
module tb_mask_a_unit;
  localparam int XLEN = 32;

  logic            g_clk = 1'b0;
  logic            g_reset;
  logic            req_valid, req_ready;
  logic [1:0]      req_op;
  logic [XLEN-1:0] req_rs1, req_rs1_hi, req_rs2, req_rs2_hi;
  logic            rng_req_valid, rng_req_ready;
  logic [XLEN-1:0] rng_data;
  logic            rsp_valid, rsp_ready;
  logic [XLEN-1:0] rsp_rd, rsp_rd_hi;
  logic            rsp_trap;

  int n_cmp = 0;
  int n_err = 0;

  always #5 g_clk = ~g_clk;

  mask_a_unit #(.XLEN(XLEN)) dut (
    .g_clk         (g_clk),
    .g_reset       (g_reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_rs1       (req_rs1),
    .req_rs1_hi    (req_rs1_hi),
    .req_rs2       (req_rs2),
    .req_rs2_hi    (req_rs2_hi),
    .rng_req_valid (rng_req_valid),
    .rng_req_ready (rng_req_ready),
    .rng_data      (rng_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rd        (rsp_rd),
    .rsp_rd_hi     (rsp_rd_hi),
    .rsp_trap      (rsp_trap)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1, rs1_hi, rs2, rs2_hi, r;
    int          stall;
    int          hold;
    logic [31:0] rd, rd_hi;
    logic        trap;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  // Reference: pick the target unmasked value, the new hi share, then rd = value - hi.
  function automatic vec_t model(input vec_t v);
    vec_t        e = v;
    logic [31:0] value;
    case (v.op)
      2'd0: begin value = v.rs1;                                    e.rd_hi = v.r; end
      2'd1: begin value = (v.rs1 + v.rs1_hi) + (v.rs2 + v.rs2_hi); e.rd_hi = v.rs1_hi + v.rs2_hi + v.r; end
      2'd2: begin value = v.rs1 + v.rs1_hi;                         e.rd_hi = v.rs1_hi + v.r; end
      default: begin value = 32'd0;                                 e.rd_hi = 32'd0; end
    endcase
    e.rd   = value - e.rd_hi;
    e.trap = (v.op == 2'd3);
    e.lat  = (v.op == 2'd3) ? 1 : 2 + v.stall;
    return e;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int          w = 0;
    int          cyc = 0;
    int          stall_left = v.stall;
    int          rng_hs = 0;
    int          lat = -1;
    logic [31:0] grd = '0;
    logic [31:0] ghi = '0;
    logic        gtrap = 1'b0;
    while (!req_ready && w < 20) begin step(); w++; end
    chk({tag, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_op = v.op;
    req_rs1 = v.rs1; req_rs1_hi = v.rs1_hi; req_rs2 = v.rs2; req_rs2_hi = v.rs2_hi;
    while (lat < 0 && cyc < 60) begin
      step(); cyc++;
      req_valid = 1'b0; req_op = 2'($urandom);
      req_rs1 = $urandom; req_rs1_hi = $urandom; req_rs2 = $urandom; req_rs2_hi = $urandom;
      rsp_ready = 1'b0;
      rng_data = $urandom;
      rng_req_ready = 1'($urandom);
      if (rng_req_valid) begin
        if (stall_left > 0) begin
          stall_left--;
          rng_req_ready = 1'b0;
        end else begin
          rng_req_ready = 1'b1;
          rng_data = v.r;
          rng_hs++;
        end
      end
      if (rsp_valid) begin
        lat = cyc; grd = rsp_rd; ghi = rsp_rd_hi; gtrap = rsp_trap;
      end
    end
    rng_req_ready = 1'b0;
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_rd"}, grd, v.rd);
    chk({tag, "_rd_hi"}, ghi, v.rd_hi);
    chk({tag, "_trap"}, gtrap, v.trap);
    chk({tag, "_rng_words"}, rng_hs, (v.op == 2'd3) ? 0 : 1);
    for (int h = 0; h < v.hold; h++) begin
      step();
      chk({tag, "_hold"}, {rsp_valid, gtrap, grd, ghi}, {1'b1, rsp_trap, rsp_rd, rsp_rd_hi});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_scrub"}, {req_ready, rsp_valid, rsp_trap, rsp_rd, rsp_rd_hi}, {1'b1, 1'b0, 1'b0, 64'd0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    bit   bad;
    tbl[0] = '{2'd0, 32'h00000001, 32'h0, 32'h0, 32'h0, 32'h12345678, 0, 0,
               32'hEDCBA989, 32'h12345678, 1'b0, 2};
    tbl[1] = '{2'd1, 32'h5, 32'hFFFFFFFC, 32'h0, 32'h1, 32'h10, 0, 0,
               32'hFFFFFFF5, 32'h0000000D, 1'b0, 2};
    tbl[2] = '{2'd2, 32'h10, 32'h20, 32'h0, 32'h0, 32'h8, 3, 0,
               32'h8, 32'h28, 1'b0, 5};
    tbl[3] = '{2'd3, 32'hDEADBEEF, 32'h1, 32'h2, 32'h3, 32'h0, 0, 2,
               32'h0, 32'h0, 1'b1, 1};
    tbl[4] = '{2'd0, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 1, 2,
               32'hBF510000, 32'h0BADF00D, 1'b0, 3};
    tbl[5] = '{2'd2, 32'h0, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1,
               32'h00000001, 32'h00000000, 1'b0, 2};
    tbl[6] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 2, 0,
               32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 4};

    g_reset = 1'b1; req_valid = 1'b0; req_op = '0;
    req_rs1 = '0; req_rs1_hi = '0; req_rs2 = '0; req_rs2_hi = '0;
    rng_req_ready = 1'b0; rng_data = '0; rsp_ready = 1'b0;
    repeat (3) step();
    g_reset = 1'b0;
    chk("reset_state", {req_ready, rng_req_valid, rsp_valid, rsp_trap, rsp_rd, rsp_rd_hi},
        {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});

    for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while waiting for randomness, coinciding with an rng handshake.
    req_valid = 1'b1; req_op = 2'd0; req_rs1 = 32'h55; req_rs1_hi = 32'h0;
    step();
    req_valid = 1'b0;
    chk("rst_in_rng_valid", rng_req_valid, 1'b1);
    rng_req_ready = 1'b1; rng_data = 32'h1234; g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    chk("rst_in_rng_state", {req_ready, rng_req_valid, rsp_valid, rsp_trap, rsp_rd, rsp_rd_hi},
        {1'b1, 1'b0, 1'b0, 1'b0, 64'd0});
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (rsp_valid || rng_req_valid || !req_ready) bad = 1'b1;
    end
    rng_req_ready = 1'b0;
    chk("rst_in_rng_quiet", bad, 1'b0);

    for (int i = 0; i < 40; i++) begin
      v.op = 2'($urandom_range(0, 3));
      v.rs1 = $urandom; v.rs1_hi = $urandom; v.rs2 = $urandom; v.rs2_hi = $urandom;
      v.r = $urandom; v.stall = $urandom_range(0, 2); v.hold = $urandom_range(0, 1);
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mask_a_unit
`default_nettype wire
